gfx_reg_file: RTL and testbench
===============================

# gfx_reg_file

Double-buffered register bank directly upstream of the graphics ASIC's sprite/score renderers. It accepts CPU writes over the chipselect/databus/data_address interface into shadow registers. On request, it commits all shadow values atomically to the active outputs at the next frame boundary, so the renderers never see a torn update mid-frame. Its active outputs drive the paddle, ball, score and game-state inputs that the renderers currently receive as constants.

## Interface
- CS_BIT, 1, index of the chipselect bit that selects this block
- H_RES, 640, horizontal resolution; x coordinates clamp to H_RES-1
- V_RES, 480, vertical resolution; y coordinates clamp to V_RES-1
- Z_MAX, 255, ball depth clamp value
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- chipselect  in  4  CPU device selects; bit CS_BIT selects this block
- databus  in  16  CPU write data
- data_address  in  4  register index
- frame_done  in  1  single-cycle pulse on the cycle the last pixel (address 0x4AFFF) is accepted by VGA
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  16 each  active paddle positions
- ball_x, ball_y, ball_z  out  16 each  active ball position
- player_1_score, player_2_score, game_state  out  16 each  active values
- commit_pending  out  1  commit armed, waiting for frame_done
- committed  out  1  one-cycle pulse on the cycle after an active update

## Operation
- Write strobe: sel = chipselect[CS_BIT]. A write is accepted only on the first cycle of sel high, i.e. sel is high now and was low last cycle. A held select produces exactly one write.
- Address map:
  - 0 p1x, 1 p1y, 2 p2x, 3 p2y, 4 ball_x, 5 ball_y, 6 ball_z, 7 p1 score, 8 p2 score, 9 game_state.
  - 0xA control: databus[0]=1 arms a commit; databus[0]=0 with databus[1]=1 cancels a pending commit.
  - 0xB–0xF: write ignored, no state change.
- Clamping is applied on write into the shadow registers, as unsigned comparisons:
  - x registers (0, 2, 4): min(data, H_RES-1).
  - y registers (1, 3, 5): min(data, V_RES-1).
  - ball_z: min(data, Z_MAX).
  - Other registers are stored unmodified.
- Commit: when frame_done and commit_pending are both high, all ten shadows copy to the active outputs in one edge. commit_pending clears, and committed pulses on the next cycle.
- Writes to shadows never alter active outputs directly.
- Simultaneous events:
  - Data write and commit in the same cycle: the commit copies the pre-write shadow value. The new value lands in the shadow and appears on the next commit.
  - Arm write and frame_done in the same cycle: no commit this frame; commit_pending is set and the commit happens at the following frame_done.
  - Cancel write and frame_done in the same cycle with pending high: the commit happens, because frame_done has priority, and pending ends low.
  - Arming while already pending: no effect.
- Reset (including mid-frame or while pending): shadows and actives both load the defaults below. commit_pending=0, committed=0, select-edge history cleared (treated as low).
  - p1 = (100, 200), p2 = (350, 250), ball = (320, 240, 0), scores 0, game_state 0.

## Timing
- Write to shadow: 1 cycle after the accepting edge.
- Active update: on the clk edge where frame_done && commit_pending. Outputs are registered, with no combinational path from any input to any output.
- committed is high for exactly one cycle, the cycle after the active update.
- Worst-case latency from an arm write to active outputs: one full frame plus 1 cycle.
- Select must go low for at least 1 cycle between writes. Back-to-back writes therefore cost a minimum of 2 cycles each.

## Structure
- Package gfx_pkg holds:
  - register index constants ADDR_P1X…ADDR_CTRL;
  - reset-default constants;
  - H_RES/V_RES defaults;
  - the last pixel address constant 19'h4AFFF, shared with the pixel-address generator that produces frame_done.
- One sub-module is natural: gfx_coord_clamp (combinational, takes address class and data, returns the clamped value), instantiated once on the write path.

## Test plan
- Reset, then hold sel for 5 cycles writing addr 0 = 150 → shadow p1x = 150 written once. paddle_1_x stays 100 until arm + frame_done, then reads 150 and committed pulses once.
- Write addr 4 = 900, addr 5 = 600, addr 6 = 300, arm, frame_done → ball = (639, 479, 255).
- Arm write and frame_done in the same cycle → no update, commit_pending=1. The next frame_done commits.
- Data write addr 7 = 5 in the same cycle as a commit → player_1_score keeps its old value. Arm again plus frame_done → reads 5.
- Arm, then cancel (databus=0x0002), then frame_done → no update, commit_pending=0. Separately, cancel coincident with frame_done while pending → update occurs.
- Arm with pending shadows, assert rst mid-frame, then frame_done → outputs equal the defaults, no committed pulse. Writes to addr 0xC have no effect.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared constants and helpers for the graphics register bank.
//   - register index map for the CPU write interface
//   - power-on / reset defaults for every register
//   - screen-size defaults and the last visible pixel address, which the
//     pixel-address generator also uses when it raises frame_done
package gfx_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 10;

   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int Z_MAX_DEF = 255;

   localparam logic [18:0] LAST_PIXEL_ADDR = 19'h4AFFF;

   localparam logic [3:0] ADDR_P1X    = 4'h0;
   localparam logic [3:0] ADDR_P1Y    = 4'h1;
   localparam logic [3:0] ADDR_P2X    = 4'h2;
   localparam logic [3:0] ADDR_P2Y    = 4'h3;
   localparam logic [3:0] ADDR_BALL_X = 4'h4;
   localparam logic [3:0] ADDR_BALL_Y = 4'h5;
   localparam logic [3:0] ADDR_BALL_Z = 4'h6;
   localparam logic [3:0] ADDR_P1S    = 4'h7;
   localparam logic [3:0] ADDR_P2S    = 4'h8;
   localparam logic [3:0] ADDR_STATE  = 4'h9;
   localparam logic [3:0] ADDR_CTRL   = 4'hA;

   localparam logic [DATA_W-1:0] RST_P1X    = 16'd100;
   localparam logic [DATA_W-1:0] RST_P1Y    = 16'd200;
   localparam logic [DATA_W-1:0] RST_P2X    = 16'd350;
   localparam logic [DATA_W-1:0] RST_P2Y    = 16'd250;
   localparam logic [DATA_W-1:0] RST_BALL_X = 16'd320;
   localparam logic [DATA_W-1:0] RST_BALL_Y = 16'd240;

   // Which clamp limit applies to a register index.
   typedef enum logic [1:0] {
      CLS_NONE,
      CLS_X,
      CLS_Y,
      CLS_Z
   } coord_cls_e;

   function automatic coord_cls_e addr_class(input logic [3:0] addr);
      case (addr)
         ADDR_P1X, ADDR_P2X, ADDR_BALL_X: addr_class = CLS_X;
         ADDR_P1Y, ADDR_P2Y, ADDR_BALL_Y: addr_class = CLS_Y;
         ADDR_BALL_Z:                     addr_class = CLS_Z;
         default:                         addr_class = CLS_NONE;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] reset_value(input int unsigned idx);
      case (idx)
         0:       reset_value = RST_P1X;
         1:       reset_value = RST_P1Y;
         2:       reset_value = RST_P2X;
         3:       reset_value = RST_P2Y;
         4:       reset_value = RST_BALL_X;
         5:       reset_value = RST_BALL_Y;
         default: reset_value = '0;
      endcase
   endfunction

endpackage

// File: rtl/gfx_coord_clamp.sv
// gfx_coord_clamp: combinational limiter on the CPU write path.
//   cls     in   coordinate class of the target register
//   data    in   raw CPU write data
//   clamped out  data limited to H_RES-1 / V_RES-1 / Z_MAX (unsigned),
//                or passed through for non-coordinate registers
module gfx_coord_clamp
   import gfx_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int Z_MAX = Z_MAX_DEF
) (
   input  coord_cls_e        cls,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] clamped
);

   localparam logic [DATA_W-1:0] X_LIM = DATA_W'(H_RES - 1);
   localparam logic [DATA_W-1:0] Y_LIM = DATA_W'(V_RES - 1);
   localparam logic [DATA_W-1:0] Z_LIM = DATA_W'(Z_MAX);

   always_comb begin
      clamped = data;
      case (cls)
         CLS_X:   if (data > X_LIM) clamped = X_LIM;
         CLS_Y:   if (data > Y_LIM) clamped = Y_LIM;
         CLS_Z:   if (data > Z_LIM) clamped = Z_LIM;
         default: clamped = data;
      endcase
   end

endmodule

// File: rtl/gfx_reg_file.sv
// gfx_reg_file: double-buffered register bank feeding the sprite/score
// renderers. CPU writes land in shadow registers; an armed commit copies
// all shadows to the active outputs together on the frame_done edge so a
// frame is never rendered from a half-updated set.
//   clk, rst        clock, synchronous active-high reset
//   chipselect      device selects; bit CS_BIT selects this block
//   databus         write data
//   data_address    register index (0-9 data, 0xA control, 0xB-0xF ignored)
//   frame_done      pulse when the last pixel of a frame is accepted
//   paddle/ball/score/game_state outputs   active (committed) values
//   commit_pending  commit armed, waiting for frame_done
//   committed       one-cycle pulse in the cycle after the active update
module gfx_reg_file
   import gfx_pkg::*;
#(
   parameter int CS_BIT = 1,
   parameter int H_RES  = H_RES_DEF,
   parameter int V_RES  = V_RES_DEF,
   parameter int Z_MAX  = Z_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        chipselect,
   input  logic [DATA_W-1:0] databus,
   input  logic [3:0]        data_address,
   input  logic              frame_done,
   output logic [DATA_W-1:0] paddle_1_x,
   output logic [DATA_W-1:0] paddle_1_y,
   output logic [DATA_W-1:0] paddle_2_x,
   output logic [DATA_W-1:0] paddle_2_y,
   output logic [DATA_W-1:0] ball_x,
   output logic [DATA_W-1:0] ball_y,
   output logic [DATA_W-1:0] ball_z,
   output logic [DATA_W-1:0] player_1_score,
   output logic [DATA_W-1:0] player_2_score,
   output logic [DATA_W-1:0] game_state,
   output logic              commit_pending,
   output logic              committed
);

   logic              sel;
   logic              sel_q;
   logic              wr_accept;
   logic              wr_ctrl;
   logic              commit;
   logic [DATA_W-1:0] clamped_data;
   logic              unused_cs;

   logic [DATA_W-1:0] shadow [NUM_REGS];
   logic [DATA_W-1:0] active [NUM_REGS];

   assign sel       = chipselect[CS_BIT];
   assign unused_cs = ^chipselect;

   // Only the rising edge of the select writes, so a held select is one write.
   assign wr_accept = sel && !sel_q;
   assign wr_ctrl   = wr_accept && (data_address == ADDR_CTRL);
   assign commit    = frame_done && commit_pending;

   gfx_coord_clamp #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .Z_MAX (Z_MAX)
   ) u_clamp (
      .cls     (addr_class(data_address)),
      .data    (databus),
      .clamped (clamped_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q          <= 1'b0;
         commit_pending <= 1'b0;
         committed      <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= reset_value(i);
            active[i] <= reset_value(i);
         end
      end else begin
         sel_q     <= sel;
         committed <= commit;

         // Non-blocking copy: a same-cycle data write is not seen by this
         // commit and waits in the shadow for the next one.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit)
               active[i] <= shadow[i];
            if (wr_accept && (data_address == 4'(i)))
               shadow[i] <= clamped_data;
         end

         // frame_done wins over a coincident arm or cancel.
         if (commit)
            commit_pending <= 1'b0;
         else if (wr_ctrl && databus[0])
            commit_pending <= 1'b1;
         else if (wr_ctrl && databus[1])
            commit_pending <= 1'b0;
      end
   end

   assign paddle_1_x     = active[0];
   assign paddle_1_y     = active[1];
   assign paddle_2_x     = active[2];
   assign paddle_2_y     = active[3];
   assign ball_x         = active[4];
   assign ball_y         = active[5];
   assign ball_z         = active[6];
   assign player_1_score = active[7];
   assign player_2_score = active[8];
   assign game_state     = active[9];

endmodule

// File: tb/tb_gfx_reg_file.sv
// tb_gfx_reg_file: directed scenarios plus randomized traffic for
// gfx_reg_file, checked every cycle against a behavioural model of the
// register bank (shadow/active arrays and a pending flag).
module tb_gfx_reg_file;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  chipselect = '0;
   logic [15:0] databus = '0;
   logic [3:0]  data_address = '0;
   logic        frame_done = 1'b0;
   logic [15:0] paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
   logic [15:0] ball_x, ball_y, ball_z;
   logic [15:0] player_1_score, player_2_score, game_state;
   logic        commit_pending, committed;

   int checks = 0;
   int failures = 0;

   gfx_reg_file dut (
      .clk            (clk),
      .rst            (rst),
      .chipselect     (chipselect),
      .databus        (databus),
      .data_address   (data_address),
      .frame_done     (frame_done),
      .paddle_1_x     (paddle_1_x),
      .paddle_1_y     (paddle_1_y),
      .paddle_2_x     (paddle_2_x),
      .paddle_2_y     (paddle_2_y),
      .ball_x         (ball_x),
      .ball_y         (ball_y),
      .ball_z         (ball_z),
      .player_1_score (player_1_score),
      .player_2_score (player_2_score),
      .game_state     (game_state),
      .commit_pending (commit_pending),
      .committed      (committed)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_shadow [10];
   int m_active [10];
   bit m_pending;
   bit m_committed;
   bit m_prev_sel;
   bit started = 0;

   function automatic int defaults(int idx);
      case (idx)
         0: return 100;
         1: return 200;
         2: return 350;
         3: return 250;
         4: return 320;
         5: return 240;
         default: return 0;
      endcase
   endfunction

   function automatic int limit(int idx, int v);
      int lim;
      lim = 65535;
      if (idx == 0 || idx == 2 || idx == 4) lim = 639;
      if (idx == 1 || idx == 3 || idx == 5) lim = 479;
      if (idx == 6) lim = 255;
      return (v > lim) ? lim : v;
   endfunction

   always @(posedge clk) begin
      bit sel_now, new_write, do_commit;
      int a;
      sel_now = chipselect[1];
      a = int'(data_address);
      if (rst) begin
         for (int i = 0; i < 10; i++) begin
            m_shadow[i] = defaults(i);
            m_active[i] = defaults(i);
         end
         m_pending   = 0;
         m_committed = 0;
         m_prev_sel  = 0;
      end else begin
         new_write = sel_now && !m_prev_sel;
         do_commit = frame_done && m_pending;
         m_committed = do_commit;
         if (do_commit) begin
            m_active  = m_shadow;
            m_pending = 0;
         end
         if (new_write) begin
            if (a < 10)
               m_shadow[a] = limit(a, int'(databus));
            else if (a == 10 && !do_commit) begin
               if (databus[0]) m_pending = 1;
               else if (databus[1]) m_pending = 0;
            end
         end
         m_prev_sel = sel_now;
      end
      started = 1;
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("p1x",       paddle_1_x,     16'(m_active[0]));
         chk("p1y",       paddle_1_y,     16'(m_active[1]));
         chk("p2x",       paddle_2_x,     16'(m_active[2]));
         chk("p2y",       paddle_2_y,     16'(m_active[3]));
         chk("ball_x",    ball_x,         16'(m_active[4]));
         chk("ball_y",    ball_y,         16'(m_active[5]));
         chk("ball_z",    ball_z,         16'(m_active[6]));
         chk("p1_score",  player_1_score, 16'(m_active[7]));
         chk("p2_score",  player_2_score, 16'(m_active[8]));
         chk("game_state",game_state,     16'(m_active[9]));
         chk("pending",   16'(commit_pending), 16'(m_pending));
         chk("committed", 16'(committed),      16'(m_committed));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      chipselect   = 4'b0010;
      data_address = a;
      databus      = d;
      cyc(1);
      chipselect = 4'b0000;
      cyc(1);
   endtask

   task automatic frame();
      frame_done = 1'b1;
      cyc(1);
      frame_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      chk("lit_reset_p1x",    paddle_1_x, 16'd100);
      chk("lit_reset_p2y",    paddle_2_y, 16'd250);
      chk("lit_reset_ball_x", ball_x,     16'd320);
      chk("lit_reset_pend",   16'(commit_pending), 16'd0);

      // Held select: only the first cycle's data (150) may land.
      chipselect = 4'b0010; data_address = 4'h0; databus = 16'd150;
      cyc(1);
      databus = 16'd151;
      cyc(4);
      chipselect = 4'b0000;
      cyc(1);
      chk("lit_p1x_before_commit", paddle_1_x, 16'd100);
      chk("lit_model_shadow_p1x",  16'(m_shadow[0]), 16'd150);
      wr(4'hA, 16'h0001);
      chk("lit_pending_armed", 16'(commit_pending), 16'd1);
      frame();
      chk("lit_p1x_committed", paddle_1_x, 16'd150);
      chk("lit_committed_pulse", 16'(committed), 16'd1);
      cyc(1);
      chk("lit_committed_low", 16'(committed), 16'd0);

      // Clamping of ball coordinates.
      wr(4'h4, 16'd900);
      wr(4'h5, 16'd600);
      wr(4'h6, 16'd300);
      wr(4'hA, 16'h0001);
      frame();
      chk("lit_ball_x_clamp", ball_x, 16'd639);
      chk("lit_ball_y_clamp", ball_y, 16'd479);
      chk("lit_ball_z_clamp", ball_z, 16'd255);

      // Arm coincident with frame_done: no commit this frame.
      wr(4'h0, 16'd200);
      chipselect = 4'b0010; data_address = 4'hA; databus = 16'h0001; frame_done = 1'b1;
      cyc(1);
      chipselect = 4'b0000; frame_done = 1'b0;
      chk("lit_arm_fd_no_update", paddle_1_x, 16'd150);
      chk("lit_arm_fd_pending",   16'(commit_pending), 16'd1);
      cyc(2);
      frame();
      chk("lit_next_fd_commit", paddle_1_x, 16'd200);

      // Data write coincident with a commit.
      wr(4'h7, 16'd3);
      wr(4'hA, 16'h0001);
      chipselect = 4'b0010; data_address = 4'h7; databus = 16'd5; frame_done = 1'b1;
      cyc(1);
      chipselect = 4'b0000; frame_done = 1'b0;
      chk("lit_score_pre_write", player_1_score, 16'd3);
      cyc(1);
      wr(4'hA, 16'h0001);
      frame();
      chk("lit_score_next_commit", player_1_score, 16'd5);

      // Cancel, then cancel coincident with frame_done.
      wr(4'h0, 16'd300);
      wr(4'hA, 16'h0001);
      wr(4'hA, 16'h0002);
      frame();
      chk("lit_cancel_no_update", paddle_1_x, 16'd200);
      chk("lit_cancel_pending",   16'(commit_pending), 16'd0);
      wr(4'hA, 16'h0001);
      chipselect = 4'b0010; data_address = 4'hA; databus = 16'h0002; frame_done = 1'b1;
      cyc(1);
      chipselect = 4'b0000; frame_done = 1'b0;
      chk("lit_cancel_fd_update",  paddle_1_x, 16'd300);
      chk("lit_cancel_fd_pending", 16'(commit_pending), 16'd0);
      cyc(1);

      // Reset while pending.
      wr(4'h0, 16'd400);
      wr(4'hA, 16'h0001);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      frame();
      chk("lit_rst_p1x",       paddle_1_x, 16'd100);
      chk("lit_rst_ball_z",    ball_z,     16'd0);
      chk("lit_rst_committed", 16'(committed), 16'd0);
      wr(4'hC, 16'd1234);
      wr(4'hA, 16'h0001);
      frame();
      chk("lit_addr_c_ignored_p1x", paddle_1_x, 16'd100);
      chk("lit_addr_c_ignored_p1s", player_1_score, 16'd0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         chipselect   = 4'($urandom);
         data_address = 4'($urandom_range(0, 15));
         if (data_address == 4'hA && $urandom_range(0, 1) == 1)
            databus = 16'($urandom_range(0, 3));
         else if ($urandom_range(0, 1) == 1)
            databus = 16'($urandom_range(0, 1000));
         else
            databus = 16'($urandom);
         frame_done = ($urandom_range(0, 7) == 0);
         rst        = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0; chipselect = '0; frame_done = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
